// File: rtl/gate_scan_controller_if.sv
// Bundles the scan request, expected table, gate feedback and scan results.
// The slave modport is the controller side; the master side drives start,
// exp_table and the gate output Y.
interface gate_scan_controller_if;
  logic       start;
  logic [3:0] exp_table;
  logic       Y;
  logic       A;
  logic       B;
  logic       busy;
  logic       done;
  logic [3:0] result;
  logic       pass;
  logic [2:0] err_count;

  modport slave (
    input  start, exp_table, Y,
    output A, B, busy, done, result, pass, err_count
  );

  modport master (
    output start, exp_table, Y,
    input  A, B, busy, done, result, pass, err_count
  );
endinterface

// File: rtl/gate_scan_controller.sv
// Exhaustive test controller for a 2-input gate. Each of the four {A,B}
// vectors is held for SETTLE_CYCLES cycles (legal range 1..15), then Y is
// sampled one cycle later and compared with a table latched at start.
// Optional build macro: STOP_ON_MISMATCH_EN ends the scan at the first
// mismatching vector instead of scanning all four.
module gate_scan_controller #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input logic                   clk,
  input logic                   reset,
  gate_scan_controller_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StDrive, StSample, StDone} state_e;

  localparam logic [3:0] CntLast = 4'(SETTLE_CYCLES - 1);

  state_e     r_state;
  logic [1:0] r_idx;
  logic [3:0] r_cnt;
  logic [3:0] r_exp;
  logic [3:0] r_result;
  logic       r_pass;
  logic [2:0] r_err;

  state_e     w_state_next;
  logic [1:0] w_idx_next;
  logic [3:0] w_cnt_next;
  logic [3:0] w_exp_next;
  logic [3:0] w_result_next;
  logic       w_pass_next;
  logic [2:0] w_err_next;
  logic [3:0] w_result_upd;
  logic       w_mismatch;

  // State and datapath registers; reset clears everything immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= StIdle;
      r_idx    <= 2'd0;
      r_cnt    <= 4'd0;
      r_exp    <= 4'd0;
      r_result <= 4'd0;
      r_pass   <= 1'b0;
      r_err    <= 3'd0;
    end else begin
      r_state  <= w_state_next;
      r_idx    <= w_idx_next;
      r_cnt    <= w_cnt_next;
      r_exp    <= w_exp_next;
      r_result <= w_result_next;
      r_pass   <= w_pass_next;
      r_err    <= w_err_next;
    end
  end

  // Next-state logic: settle counting, sampling, scoring and scan sequencing.
  always_comb begin
    w_state_next  = r_state;
    w_idx_next    = r_idx;
    w_cnt_next    = r_cnt;
    w_exp_next    = r_exp;
    w_result_next = r_result;
    w_pass_next   = r_pass;
    w_err_next    = r_err;

    // Result as it will look once the current vector's Y is captured.
    w_result_upd        = r_result;
    w_result_upd[r_idx] = bus.Y;
    w_mismatch          = (bus.Y != r_exp[r_idx]);

    unique case (r_state)
      StIdle: begin
        if (bus.start) begin
          w_state_next  = StDrive;
          w_idx_next    = 2'd0;
          w_cnt_next    = 4'd0;
          w_exp_next    = bus.exp_table;
          w_result_next = 4'd0;
          w_err_next    = 3'd0;
          w_pass_next   = 1'b0;
        end
      end
      StDrive: begin
        if (r_cnt == CntLast) begin
          w_state_next = StSample;
          w_cnt_next   = 4'd0;
        end else begin
          w_cnt_next = r_cnt + 4'd1;
        end
      end
      StSample: begin
        w_result_next = w_result_upd;
        if (w_mismatch) begin
          w_err_next = r_err + 3'd1;
        end
`ifdef STOP_ON_MISMATCH_EN
        if (w_mismatch) begin
          w_state_next = StDone;
          w_pass_next  = 1'b0;
        end else if (r_idx == 2'd3) begin
          w_state_next = StDone;
          w_pass_next  = (w_result_upd == r_exp);
        end else begin
          w_state_next = StDrive;
          w_idx_next   = r_idx + 2'd1;
        end
`else
        if (r_idx == 2'd3) begin
          w_state_next = StDone;
          w_pass_next  = (w_result_upd == r_exp);
        end else begin
          w_state_next = StDrive;
          w_idx_next   = r_idx + 2'd1;
        end
`endif
      end
      StDone: begin
        w_state_next = StIdle;
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  // Moore outputs; the vector is only presented while driving or sampling.
  always_comb begin
    bus.busy      = (r_state != StIdle);
    bus.done      = (r_state == StDone);
    bus.A         = 1'b0;
    bus.B         = 1'b0;
    if (r_state == StDrive || r_state == StSample) begin
      bus.A = r_idx[1];
      bus.B = r_idx[0];
    end
    bus.result    = r_result;
    bus.pass      = r_pass;
    bus.err_count = r_err;
  end

endmodule

// File: tb/tb_gate_scan_controller.sv
// Directed bench for gate_scan_controller: XOR, stuck-at-0 and AND gate
// models, asynchronous mid-scan reset and back-to-back scans.
module tb_gate_scan_controller;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic y_zero = 1'b0;
  logic sel = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  gate_scan_controller_if if1 ();
  gate_scan_controller_if if2 ();

  // Gate models: DUT1 sees XOR (or a stuck-at-0 output), DUT2 sees AND.
  assign if1.Y = y_zero ? 1'b0 : (if1.A ^ if1.B);
  assign if2.Y = if2.A & if2.B;

  gate_scan_controller #(.SETTLE_CYCLES(1)) u_dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (if1.slave)
  );

  gate_scan_controller #(.SETTLE_CYCLES(3)) u_dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (if2.slave)
  );

  // Observation mux so one scan task serves both DUTs.
  logic [1:0] ob_ab;
  logic       ob_busy, ob_done, ob_pass;
  logic [3:0] ob_result;
  logic [2:0] ob_err;
  always_comb begin
    ob_ab     = sel ? {if2.A, if2.B} : {if1.A, if1.B};
    ob_busy   = sel ? if2.busy : if1.busy;
    ob_done   = sel ? if2.done : if1.done;
    ob_pass   = sel ? if2.pass : if1.pass;
    ob_result = sel ? if2.result : if1.result;
    ob_err    = sel ? if2.err_count : if1.err_count;
  end

  // Pulses start for one edge, then checks A/B and done after every edge up to
  // done_edge, the final scores, and that they hold one cycle later.
  task automatic run_scan(input logic use2, input int sp1, input int done_edge,
                          input logic [3:0] exp_tab, input logic [3:0] exp_res,
                          input logic exp_pass, input logic [2:0] exp_err,
                          input int chg_edge, input logic [3:0] chg_val,
                          input string name);
    logic [1:0] exp_ab;
    sel = use2;
    @(negedge clk);
    if (use2) begin
      if2.exp_table = exp_tab;
      if2.start = 1'b1;
    end else begin
      if1.exp_table = exp_tab;
      if1.start = 1'b1;
    end
    @(posedge clk);
    #1;
    if1.start = 1'b0;
    if2.start = 1'b0;
    n_checks++;
    if (ob_busy !== 1'b1) $display("FAIL %s busy edge0: got %b want 1", name, ob_busy);
    else n_pass++;
    for (int k = 1; k <= done_edge; k++) begin
      @(posedge clk);
      #1;
      exp_ab = (k < done_edge) ? 2'(k / sp1) : 2'b00;
      n_checks++;
      if (ob_ab !== exp_ab)
        $display("FAIL %s ab edge %0d: got %b want %b", name, k, ob_ab, exp_ab);
      else n_pass++;
      n_checks++;
      if (ob_done !== (k == done_edge))
        $display("FAIL %s done edge %0d: got %b want %b", name, k, ob_done, k == done_edge);
      else n_pass++;
      if (k == chg_edge) begin
        if (use2) if2.exp_table = chg_val;
        else if1.exp_table = chg_val;
      end
    end
    n_checks++;
    if (ob_result !== exp_res)
      $display("FAIL %s result: got %b want %b", name, ob_result, exp_res);
    else n_pass++;
    n_checks++;
    if (ob_pass !== exp_pass) $display("FAIL %s pass: got %b want %b", name, ob_pass, exp_pass);
    else n_pass++;
    n_checks++;
    if (ob_err !== exp_err) $display("FAIL %s err_count: got %0d want %0d", name, ob_err, exp_err);
    else n_pass++;
    @(posedge clk);
    #1;
    n_checks++;
    if ({ob_busy, ob_done} !== 2'b00)
      $display("FAIL %s idle after done: got busy/done %b want 00", name, {ob_busy, ob_done});
    else n_pass++;
    n_checks++;
    if ({ob_result, ob_pass, ob_err} !== {exp_res, exp_pass, exp_err})
      $display("FAIL %s hold: got %b want %b", name, {ob_result, ob_pass, ob_err},
               {exp_res, exp_pass, exp_err});
    else n_pass++;
  endtask

  task automatic test_reset();
    if1.start = 1'b0;
    if2.start = 1'b0;
    if1.exp_table = 4'd0;
    if2.exp_table = 4'd0;
    #1 reset = 1'b1;
    #2;
    n_checks++;
    if ({if1.A, if1.B, if1.busy, if1.done, if1.result, if1.pass, if1.err_count} !== 12'd0)
      $display("FAIL reset dut1: got %b want 0", {if1.A, if1.B, if1.busy, if1.done,
               if1.result, if1.pass, if1.err_count});
    else n_pass++;
    n_checks++;
    if ({if2.A, if2.B, if2.busy, if2.done, if2.result, if2.pass, if2.err_count} !== 12'd0)
      $display("FAIL reset dut2: got %b want 0", {if2.A, if2.B, if2.busy, if2.done,
               if2.result, if2.pass, if2.err_count});
    else n_pass++;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_xor_scan();
    y_zero = 1'b0;
    run_scan(1'b0, 2, 8, 4'b0110, 4'b0110, 1'b1, 3'd0, 0, 4'd0, "xor");
  endtask

  task automatic test_stuck_zero();
    y_zero = 1'b1;
`ifdef STOP_ON_MISMATCH_EN
    run_scan(1'b0, 2, 4, 4'b0110, 4'b0000, 1'b0, 3'd1, 0, 4'd0, "stuck0");
`else
    run_scan(1'b0, 2, 8, 4'b0110, 4'b0000, 1'b0, 3'd2, 0, 4'd0, "stuck0");
`endif
    y_zero = 1'b0;
  endtask

  task automatic test_and_scan();
    run_scan(1'b1, 4, 16, 4'b1000, 4'b1000, 1'b1, 3'd0, 0, 4'd0, "and_s3");
  endtask

  task automatic test_reset_mid_scan();
    sel = 1'b0;
    y_zero = 1'b0;
    @(negedge clk);
    if1.exp_table = 4'b0110;
    if1.start = 1'b1;
    @(posedge clk);
    #1 if1.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    n_checks++;
    if ({if1.A, if1.B, if1.result} !== 6'b10_0010)
      $display("FAIL midrst pre: got ab/result %b want 100010", {if1.A, if1.B, if1.result});
    else n_pass++;
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if ({if1.A, if1.B, if1.busy, if1.done, if1.result, if1.pass, if1.err_count} !== 12'd0)
      $display("FAIL midrst async clear: got %b want 0", {if1.A, if1.B, if1.busy, if1.done,
               if1.result, if1.pass, if1.err_count});
    else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    run_scan(1'b0, 2, 8, 4'b0110, 4'b0110, 1'b1, 3'd0, 3, 4'b1001, "after_rst");
  endtask

  task automatic test_back_to_back();
    sel = 1'b0;
    y_zero = 1'b0;
    @(negedge clk);
    if1.exp_table = 4'b0110;
    if1.start = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (if1.done !== (k == 8 || k == 18 || k == 28))
        $display("FAIL b2b done edge %0d: got %b want %b", k, if1.done,
                 (k == 8 || k == 18 || k == 28));
      else n_pass++;
    end
    if1.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({if1.busy, if1.result, if1.pass} !== 6'b0_0110_1)
      $display("FAIL b2b end: got busy/result/pass %b want 001101",
               {if1.busy, if1.result, if1.pass});
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_xor_scan();
    test_stuck_zero();
    test_and_scan();
    test_reset_mid_scan();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/gate_scan_controller.md
GATE_SCAN_CONTROLLER -- requirements
Module: gate_scan_controller

Interface
REQ-001 Parameter SETTLE_CYCLES, default 1: cycles each vector is held before Y is sampled; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  scan request; sampled only in IDLE.
REQ-005 exp_table  input  4  expected Y per vector; bit index = {A,B}.
REQ-006 Y  input  1  output of the 2-input gate under control.
REQ-007 A  output  1  gate input A.
REQ-008 B  output  1  gate input B.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 done  output  1  one-cycle pulse at scan end.
REQ-011 result  output  4  captured Y per vector; bit index = {A,B}.
REQ-012 pass  output  1  high when result equals the latched exp_table; valid from done onward.
REQ-013 err_count  output  3  number of mismatching vectors, 0..4.

Function
REQ-014 The FSM SHALL have states IDLE, DRIVE, SAMPLE and DONE.
REQ-015 IDLE with start=1 at a clock edge SHALL go to DRIVE with these effects:
- vector index = 0;
- exp_table latched internally;
- result, err_count and pass cleared.
REQ-016 Vector order SHALL be index 0..3, with {A,B} = 00, 01, 10, 11.
- A/B SHALL equal the current index throughout DRIVE and SAMPLE.
- A/B SHALL be 0 in IDLE and DONE.
REQ-017 DRIVE SHALL last exactly SETTLE_CYCLES cycles, counted by an internal counter, then go to SAMPLE.
REQ-018 SAMPLE SHALL last one cycle; at its closing edge:
- Y is written to result[index];
- err_count increments if Y differs from the latched exp_table[index].
REQ-019 Leaving SAMPLE:
- index 3 SHALL go to DONE;
- otherwise index increments and the FSM goes to DRIVE.
REQ-020 DONE SHALL last one cycle with done=1, then go to IDLE.
REQ-021 pass SHALL be updated on entry to DONE.
REQ-022 Counting the start-sampling edge as edge 0, done SHALL be high after edge 4*(SETTLE_CYCLES+1).
REQ-023 start SHALL be ignored while busy=1.
- start held high continuously SHALL launch a new scan from IDLE at the edge after DONE.
REQ-024 exp_table changes during a scan SHALL have no effect.
REQ-025 result, pass and err_count SHALL hold their values from DONE until the next accepted start.

Reset
REQ-026 reset=1 SHALL immediately force the following, at any time including mid-scan, without waiting for clk:
- state IDLE;
- A=0, B=0, busy=0, done=0;
- result=0, pass=0, err_count=0;
- index and settle counter = 0.
REQ-027 After reset deasserts, the next start SHALL run a complete normal scan.

Configuration
REQ-028 With macro STOP_ON_MISMATCH_EN defined, the first mismatch in SAMPLE SHALL:
- move the FSM directly to DONE;
- leave err_count=1;
- leave unscanned result bits at 0;
- set pass=0.
REQ-029 Without STOP_ON_MISMATCH_EN, all four vectors SHALL always be scanned.

Verification
REQ-030 XOR model on Y, exp_table=0110, SETTLE_CYCLES=1, start pulse:
- A/B sequence 00,01,10,11, each held 2 cycles;
- done after edge 8;
- result=0110, pass=1, err_count=0.
REQ-031 Y tied 0, exp_table=0110, macro undefined:
- done after edge 8;
- result=0000, pass=0, err_count=2.
REQ-032 Same as REQ-031 with STOP_ON_MISMATCH_EN defined:
- done after edge 4 (after the index-1 SAMPLE);
- result=0000, err_count=1, pass=0.
REQ-033 AND model on Y, exp_table=1000, SETTLE_CYCLES=3:
- each vector held 4 cycles;
- done after edge 16;
- result=1000, pass=1.
REQ-034 Reset pulse during index-2 DRIVE:
- A=B=0, busy=0, outputs 0 immediately;
- exp_table changed during the subsequent scan is ignored;
- that scan matches REQ-030.
REQ-035 start held high for 30 cycles (XOR model):
- start ignored while busy;
- second scan begins the edge after DONE;
- done pulses after edges 8 and 18.
